// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated TX FIFO.
// Supports a runtime baud divisor, 1-16 data bits, LSB/MSB-first order,
// none/odd/even/mark/space parity, 1-4 stop bits and break generation.
// Each frame runs from a shadow copy of the configuration, so register
// writes made mid-frame only affect the next frame.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       data_num,
    input  logic [2:0]       parity_mode,
    input  logic [1:0]       stop_num,
    input  logic             lsb_first,
    input  logic             tx_en,
    input  logic             brk_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [LW-1:0]    fifo_level,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             uart_txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    // FIFO storage and bookkeeping
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          push, pop;

    // FSM state and counters
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             brk_tail_reg, brk_tail_next;
    logic             txd_reg, txd_next;

    // Per-frame shadow of the word and configuration
    logic [15:0]      sh_data_reg;
    logic [DIV_W-1:0] sh_div_reg;
    logic [3:0]       sh_num_reg;
    logic [2:0]       sh_par_reg;
    logic [1:0]       sh_stop_reg;
    logic             sh_lsb_reg;

    // Derived values
    logic [15:0]      data_mask;
    logic [DIV_W-1:0] sh_bmax, live_bmax;
    logic             bit_end, par_en, par_bit;
    logic [3:0]       data_idx;

    assign in_ready   = (level_reg < LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_level = level_reg;
    assign tx_busy    = (state_reg != ST_IDLE);
    assign uart_txd   = txd_reg;

    // Divisors 0 and 1 both give a two-cycle bit, so clamp the terminal count at 1.
    assign sh_bmax   = (sh_div_reg == '0) ? DIV_W'(1) : sh_div_reg;
    assign live_bmax = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign bit_end   = (baud_cnt_reg == sh_bmax);

    assign par_en  = (sh_par_reg >= 3'd1) && (sh_par_reg <= 3'd4);
    assign par_bit = (sh_par_reg == 3'd1) ? ~^sh_data_reg :
                     (sh_par_reg == 3'd2) ?  ^sh_data_reg :
                     (sh_par_reg == 3'd3);

    // MSB-first walks the frame from the top configured bit downwards.
    assign data_idx = sh_lsb_reg ? bit_cnt_next : (sh_num_reg - bit_cnt_next);

    // Bits above the configured frame width are cleared when a word is popped.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mask
            assign data_mask[gi] = (data_num >= 4'(gi));
        end
    endgenerate

    // FIFO array write port; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Registered read of the head word together with the frame configuration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_data_reg <= '0;
            sh_div_reg  <= '0;
            sh_num_reg  <= '0;
            sh_par_reg  <= '0;
            sh_stop_reg <= '0;
            sh_lsb_reg  <= 1'b0;
        end else if (pop) begin
            sh_data_reg <= mem[rd_ptr_reg] & data_mask;
            sh_div_reg  <= baud_div;
            sh_num_reg  <= data_num;
            sh_par_reg  <= parity_mode;
            sh_stop_reg <= stop_num;
            sh_lsb_reg  <= lsb_first;
        end
    end

    // State register, counters and the registered serial line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            brk_tail_reg <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            brk_tail_reg <= brk_tail_next;
            txd_reg      <= txd_next;
        end
    end

    // Next-state logic: sequences the frame and clears counters on every state entry.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg + 1'b1;
        bit_cnt_next  = bit_cnt_reg;
        brk_tail_next = brk_tail_reg;
        pop           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                brk_tail_next = 1'b0;
                if (brk_req) begin
                    state_next = ST_BREAK;
                end else if (tx_en && (level_reg != '0)) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt_reg == sh_num_reg) begin
                        bit_cnt_next = '0;
                        state_next   = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt_reg == {2'b00, sh_stop_reg}) begin
                        bit_cnt_next = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Hold the line low while requested, then one mark bit at the live divisor.
                if (!brk_tail_reg) begin
                    baud_cnt_next = '0;
                    if (!brk_req) brk_tail_next = 1'b1;
                end else if (baud_cnt_reg == live_bmax) begin
                    baud_cnt_next = '0;
                    brk_tail_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                brk_tail_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // Output logic: line level for the state being entered, and the end-of-frame pulse.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = sh_data_reg[data_idx];
            ST_PARITY: txd_next = par_bit;
            ST_BREAK:  txd_next = brk_tail_next;
            default:   txd_next = 1'b1;
        endcase
        tx_done = (state_reg == ST_STOP) && bit_end &&
                  (bit_cnt_reg == {2'b00, sh_stop_reg});
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated TX FIFO, a runtime-programmable baud divisor and a runtime-selectable frame format. Frames are 1–16 data bits, LSB- or MSB-first, with none/odd/even/mark/space parity and 1–4 stop bits. The block also generates break conditions. It sits behind the APB UART register block, which drives the configuration and pushes words over a valid/ready interface.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, ≥2
DIV_W, 16, baud divisor width
LW, $clog2(FIFO_DEPTH)+1, FIFO level width (derived, not overridable)

Ports:
clk  in  1  system clock
rstn  in  1  reset
baud_div  in  DIV_W  bit period = baud_div+1 clk cycles; values 0 and 1 both give 2 cycles
data_num  in  4  data bits per frame = data_num+1 (1..16)
parity_mode  in  3  0 none, 1 odd, 2 even, 3 mark(1), 4 space(0), 5–7 none
stop_num  in  2  stop bits = stop_num+1 (1..4)
lsb_first  in  1  1 = LSB transmitted first
tx_en  in  1  permits starting new frames
brk_req  in  1  level request for a break condition
in_valid  in  1  write request
in_ready  out  1  FIFO not full
in_data  in  16  word to send; bits above the frame width are ignored
fifo_level  out  LW  number of occupied FIFO entries
tx_busy  out  1  FSM not in IDLE
tx_done  out  1  one-cycle pulse at the end of each frame
uart_txd  out  1  serial line, registered

Behaviour:
- Reset is asynchronous and active-low on rstn; clock is clk.
- Reset values: uart_txd=1, tx_busy=0, tx_done=0, fifo_level=0, in_ready=1. The FIFO pointers are cleared and the FSM returns to IDLE. Reset mid-frame truncates the frame immediately (txd=1 on assertion).
- FIFO: a write occurs on in_valid&&in_ready. in_ready=(fifo_level<FIFO_DEPTH). A write while full is impossible by handshake; in_valid is held without effect.
- Simultaneous write and pop leaves fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH. Word order is strictly FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE transitions:
  - If brk_req=1, go to BREAK. Break has priority over the FIFO.
  - Else if tx_en && fifo_level≠0, pop the head word and go to START.
  - Else stay in IDLE with txd=1.
- Frame start latches into a shadow register: the popped word masked to data_num+1 bits, baud_div, data_num, parity_mode, stop_num and lsb_first. Configuration changes mid-frame take effect at the next frame only.
- Baud counter: cleared on every state entry and counts 0..max(baud_div,1). Every bit (start, data, parity, stop) lasts exactly max(baud_div,1)+1 cycles.
- Line levels per state:
  - START: txd=0.
  - DATA: txd = current data bit, selected by a bit counter 0..data_num. With lsb_first, bit index = counter; otherwise bit index = data_num−counter.
  - PARITY: entered only if parity_mode is 1–4. Odd parity = ~^masked_data, even = ^masked_data, mark = 1, space = 0.
  - STOP: txd=1 for stop_num+1 bit periods.
- State sequence: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- tx_done pulses for one cycle on the last cycle of the final stop bit.
- Back-to-back frames: if the FIFO is non-empty at the end of STOP, the FSM passes through IDLE for exactly one cycle (txd=1) and then starts the next frame.
- Latency: for a word accepted at edge k into an empty FIFO with FSM in IDLE and tx_en=1, the pop occurs at edge k+1 and txd=0 is driven from edge k+1.
- Frame length = (max(baud_div,1)+1) × (1 + data_num+1 + parity + stop_num+1) cycles.
- tx_en deasserted mid-frame: the current frame completes and no further pops occur.
- brk_req asserted mid-frame: the request is honoured only after the frame completes and the FSM reaches IDLE.
- BREAK: txd=0 while brk_req=1. After brk_req falls, txd=1 for one bit period (using the current baud_div), then the FSM returns to IDLE. tx_done is not pulsed for a break.
- tx_busy=1 in every state except IDLE.

Test Plan:
1. baud_div=3, data_num=7, parity 0, stop_num=0, lsb_first=1; write 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Frame is 40 cycles; tx_done pulses on cycle 40 after the start edge; fifo_level returns to 0.
2. data_num=4, in_data=0xFFFF (masked to 0x1F), baud_div=1 → even parity bit=1, odd parity bit=0, mark=1, space=0. Frames are 8 bit-periods of 2 cycles each.
3. data_num=15, lsb_first=0, in_data=0x8001, stop_num=3 → txd shows 0, then 1, then fourteen 0s, then 1, then 4 stop bits at 1. Frame is 21 bit periods.
4. FIFO_DEPTH=8, tx_en=0, hold in_valid for 9 cycles → 8 words accepted, in_ready=0, fifo_level=8. Set tx_en=1 → 8 frames in write order, each separated by 1 idle cycle; in_ready rises after the first pop.
5. brk_req raised mid-frame for 20 cycles with baud_div=3 → current frame completes, then txd=0 until brk_req falls, then txd=1 for 4 cycles, then IDLE. No tx_done pulse for the break.
6. rstn pulsed low during the DATA state with 3 words queued → txd=1 immediately, fifo_level=0, tx_busy=0. After release, no frame starts until a new write.
